// File: rtl/alu_mul_sequencer_if.sv
// Bundle of signals between the EX stage, the shared 16-bit ALU and the multiply sequencer.
//   slave  : the sequencer side (takes EX traffic and ALU results, drives ALU operands/status)
//   master : the environment side (EX stage issuing work plus the ALU returning results)
// Signals:
//   start, mul_a, mul_b                    multiply request and operands
//   ex_ALU_control, ex_Bus_A, ex_Bus_B     EX-stage ALU traffic passed through when idle
//   ALU_out, zero                          result and zero flag returned by the ALU
//   ALU_control, Bus_A_ALU, Bus_B_ALU      control/operands presented to the ALU
//   stall, busy, done                      pipeline hold, run status, completion pulse
//   product, overflow                      held result of the last completed multiply
interface alu_mul_sequencer_if;
   logic        start;
   logic [15:0] mul_a;
   logic [15:0] mul_b;
   logic [3:0]  ex_ALU_control;
   logic [15:0] ex_Bus_A;
   logic [15:0] ex_Bus_B;
   logic [15:0] ALU_out;
   logic        zero;
   logic [3:0]  ALU_control;
   logic [15:0] Bus_A_ALU;
   logic [15:0] Bus_B_ALU;
   logic        stall;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic        overflow;

   modport slave (
      input  start, mul_a, mul_b, ex_ALU_control, ex_Bus_A, ex_Bus_B, ALU_out, zero,
      output ALU_control, Bus_A_ALU, Bus_B_ALU, stall, busy, done, product, overflow
   );

   modport master (
      output start, mul_a, mul_b, ex_ALU_control, ex_Bus_A, ex_Bus_B, ALU_out, zero,
      input  ALU_control, Bus_A_ALU, Bus_B_ALU, stall, busy, done, product, overflow
   );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned 16x16 shift-add multiplier that borrows the EX-stage ALU.
// When idle the EX-stage control/operands pass straight through to the ALU. An accepted
// start takes over the ALU and walks ADD/SHL/SHR iterations until the remaining multiplier
// is zero, then publishes the low 16 bits of the product and a sticky overflow flag.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any multiply in flight
//   bus   : alu_mul_sequencer_if.slave (request, passthrough, ALU return, status, result)
module alu_mul_sequencer #(
   parameter logic [3:0] OP_ADD = 4'b0000,
   parameter logic [3:0] OP_SLL = 4'b0110,
   parameter logic [3:0] OP_SRL = 4'b0111
) (
   input logic                  clk,
   input logic                  rst_n,
   alu_mul_sequencer_if.slave   bus
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StAdd  = 3'd1;
   localparam logic [2:0] StShl  = 3'd2;
   localparam logic [2:0] StShr  = 3'd3;
   localparam logic [2:0] StDone = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] mcand_q, mcand_d;
   logic [15:0] mult_q, mult_d;
   logic [15:0] product_q, product_d;
   // Sticky flag accumulated during a run; only copied to the visible flag in StDone.
   logic        ovf_run_q, ovf_run_d;
   logic        overflow_q, overflow_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         acc_q      <= '0;
         mcand_q    <= '0;
         mult_q     <= '0;
         product_q  <= '0;
         ovf_run_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mult_q     <= mult_d;
         product_q  <= product_d;
         ovf_run_q  <= ovf_run_d;
         overflow_q <= overflow_d;
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mult_d     = mult_q;
      product_d  = product_q;
      ovf_run_d  = ovf_run_q;
      overflow_d = overflow_q;

      case (state_q)
         StIdle: begin
            if (bus.start) begin
               acc_d     = '0;
               mcand_d   = bus.mul_a;
               mult_d    = bus.mul_b;
               ovf_run_d = 1'b0;
               if (bus.mul_b == 16'd0) begin
                  state_d = StDone;
               end else if (bus.mul_b[0]) begin
                  state_d = StAdd;
               end else begin
                  state_d = StShl;
               end
            end
         end

         StAdd: begin
            acc_d = bus.ALU_out;
            // Unsigned sum smaller than an addend means it wrapped past 2^16.
            if (bus.ALU_out < acc_q) begin
               ovf_run_d = 1'b1;
            end
            state_d = StShl;
         end

         StShl: begin
            mcand_d = bus.ALU_out;
            // Losing a multiplicand bit matters only if more multiplier bits remain.
            if (mcand_q[15] && (mult_q[15:1] != 15'd0)) begin
               ovf_run_d = 1'b1;
            end
            state_d = StShr;
         end

         StShr: begin
            mult_d = bus.ALU_out;
            if (bus.zero) begin
               state_d = StDone;
            end else if (bus.ALU_out[0]) begin
               state_d = StAdd;
            end else begin
               state_d = StShl;
            end
         end

         StDone: begin
            product_d  = acc_q;
            overflow_d = ovf_run_q;
            state_d    = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ALU ownership: the sequencer drives the ALU only while iterating.
   always_comb begin
      bus.ALU_control = bus.ex_ALU_control;
      bus.Bus_A_ALU   = bus.ex_Bus_A;
      bus.Bus_B_ALU   = bus.ex_Bus_B;
      case (state_q)
         StAdd: begin
            bus.ALU_control = OP_ADD;
            bus.Bus_A_ALU   = acc_q;
            bus.Bus_B_ALU   = mcand_q;
         end
         StShl: begin
            bus.ALU_control = OP_SLL;
            bus.Bus_A_ALU   = mcand_q;
            bus.Bus_B_ALU   = '0;
         end
         StShr: begin
            bus.ALU_control = OP_SRL;
            bus.Bus_A_ALU   = mult_q;
            bus.Bus_B_ALU   = '0;
         end
         default: begin
         end
      endcase
   end

   logic busy_w;
   assign busy_w = (state_q == StAdd) || (state_q == StShl) || (state_q == StShr);

   assign bus.busy     = busy_w;
   assign bus.done     = (state_q == StDone);
   // Hold the issuing instruction from the accept cycle until the result is registered.
   assign bus.stall    = busy_w || ((state_q == StIdle) && bus.start) || (state_q == StDone);
   assign bus.product  = product_q;
   assign bus.overflow = overflow_q;

endmodule
